// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding and the
// default counter/limit width.
package timer_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEARING,
    RUNNING,
    PAUSED,
    EXPIRED
  } timer_state_t;

endpackage

// File: rtl/timer_sequencer_tick_prescaler.sv
// Tick prescaler: counts 0..PRESCALE-1 while enabled, wrapping to 0, and
// flags the terminal value so the sequencer can emit one increment per period.
module tick_prescaler #(
  parameter  int PRESCALE = 833333,
  localparam int PRE_W    = $clog2(PRESCALE + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             en,
  input  logic             clr,
  output logic             tc,
  output logic [PRE_W-1:0] value
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

  assign tc = (value == LAST);

  // Clear beats enable; when disabled the value is held so a pause resumes
  // mid-period instead of restarting it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= tc ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: drives clear/countup of an external event counter and flags
// expiry against a latched limit. Define TIMER_SEQ_AUTO_RELOAD_EN for a periodic timer.
module timer_sequencer #(
  parameter int CNT_W    = timer_pkg::CNT_W,
  parameter int PRESCALE = 833333
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             stop,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] count_in,
  output logic             countup,
  output logic             clear,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             done
);

  import timer_pkg::*;

  localparam int PRE_W = $clog2(PRESCALE + 1);

  timer_state_t     state;
  logic [CNT_W-1:0] limit_q;
  logic [PRE_W-1:0] prescaler;
  logic             pre_tc;
  logic             below_limit;
  logic             stop_acc;

  assign below_limit = (count_in < limit_q);
  assign stop_acc    = stop && (state != IDLE);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .en     (state == RUNNING),
    .clr    (stop_acc || start),
    .tc     (pre_tc),
    .value  (prescaler)
  );

  // Gating on below_limit means the counter can never overshoot the limit.
  assign countup = (state == RUNNING) && pre_tc && below_limit;
  assign running = (state == RUNNING);
  assign paused  = (state == PAUSED);
  assign expired = (state == EXPIRED);

  // Single-process FSM: clear is raised on the edge that enters CLEARING (or
  // IDLE via stop) and done on the edge that enters EXPIRED from RUNNING.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      limit_q <= '0;
      clear   <= 1'b0;
      done    <= 1'b0;
    end else begin
      clear <= 1'b0;
      done  <= 1'b0;
      if (stop_acc) begin
        state <= IDLE;
        clear <= 1'b1;
      end else if (start) begin
        state   <= CLEARING;
        limit_q <= limit;
        clear   <= 1'b1;
      end else begin
        unique case (state)
          CLEARING: state <= RUNNING;
          RUNNING: begin
            if (!below_limit) begin
              state <= EXPIRED;
              done  <= 1'b1;
            end else if (pause) begin
              state <= PAUSED;
            end
          end
          PAUSED: begin
            if (resume) state <= RUNNING;
          end
          EXPIRED: begin
`ifdef TIMER_SEQ_AUTO_RELOAD_EN
            state <= CLEARING;
            clear <= 1'b1;
`else
            state <= EXPIRED;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  prescaler_in_range: assert property (
    @(posedge Clk) disable iff (!Reset_n) prescaler <= PRE_W'(PRESCALE - 1)
  );

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer with PRESCALE=4 driving a behavioural event counter;
// per-cycle expectations are queued on drive and popped when outputs are sampled.
module tb_timer_sequencer;

  localparam int CNT_W    = 32;
  localparam int PRESCALE = 4;

  typedef struct packed {
    logic             start;
    logic             pause;
    logic             resume;
    logic             stop;
    logic [CNT_W-1:0] limit;
  } in_t;

  typedef struct packed {
    logic             countup;
    logic             clear;
    logic             running;
    logic             paused;
    logic             expired;
    logic             done;
    logic [CNT_W-1:0] count;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             start, pause, resume, stop;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count = '0;
  logic             countup, clear, running, paused, expired, done;

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  out_t exp_q[$];
  vec_t vecs[32];

  timer_sequencer #(
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .pause   (pause),
    .resume  (resume),
    .stop    (stop),
    .limit   (limit),
    .count_in(count),
    .countup (countup),
    .clear   (clear),
    .running (running),
    .paused  (paused),
    .expired (expired),
    .done    (done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle <= cycle + 1;

  // External event counter: countup has priority over its synchronous clear.
  always @(posedge Clk) begin
    if (countup)    count <= count + 1'b1;
    else if (clear) count <= '0;
  end

  function automatic in_t cmd(logic st, logic pa, logic re, logic sp, int lim);
    return '{st, pa, re, sp, CNT_W'(lim)};
  endfunction

  function automatic out_t outs(logic cu, logic cl, logic ru, logic pa, logic ex,
                                logic dn, int c);
    return '{cu, cl, ru, pa, ex, dn, CNT_W'(c)};
  endfunction

  // Expected outputs in the r-th RUNNING cycle after entry with the given limit.
  function automatic out_t runOut(int r, int lim);
    return outs((r % PRESCALE == PRESCALE - 1) && (r / PRESCALE < lim),
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r / PRESCALE);
  endfunction

  task automatic checkOutput(input string tag);
    out_t got, e;
    got = {countup, clear, running, paused, expired, done, count};
    e   = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got cu=%b cl=%b run=%b pau=%b exp=%b done=%b cnt=%0d required cu=%b cl=%b run=%b pau=%b exp=%b done=%b cnt=%0d",
               tag, cycle, got.countup, got.clear, got.running, got.paused, got.expired,
               got.done, got.count, e.countup, e.clear, e.running, e.paused, e.expired,
               e.done, e.count);
    end
  endtask

  task automatic applyStimulus(input in_t i, input out_t e, input string tag);
    @(negedge Clk);
    {start, pause, resume, stop, limit} = i;
    exp_q.push_back(e);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkReset(input string tag);
    checks++;
    if ({countup, clear, running, paused, expired, done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL %s got cu=%b cl=%b run=%b pau=%b exp=%b done=%b required all 0",
               tag, countup, clear, running, paused, expired, done);
    end
  endtask

  task automatic runSpan(input int r0, input int r1, input int lim, input string tag);
    for (int r = r0; r <= r1; r++) applyStimulus(cmd(0, 0, 0, 0, 0), runOut(r, lim), tag);
  endtask

  task automatic startRun(input int lim, input out_t at_start, input string tag);
    applyStimulus(cmd(1, 0, 0, 0, lim), at_start, tag);
    applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, int'(at_start.count)), tag);
  endtask

  task automatic expireSteps(input int lim, input int n, input string tag);
    applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 1, 1, lim), tag);
    for (int k = 1; k < n; k++) applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 1, 0, lim), tag);
  endtask

  initial begin
    Reset_n = 1'b0;
    {start, pause, resume, stop, limit} = '0;
    #1;
    checkReset("reset_state");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

`ifdef TIMER_SEQ_AUTO_RELOAD_EN
    $display("[TB] auto-reload: limit=2 periodic run");
    startRun(2, outs(0, 0, 0, 0, 0, 0, 0), "reload_start");
    for (int k = 0; k < 3; k++) begin
      runSpan(0, 2 * PRESCALE, 2, "reload_run");
      applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 1, 1, 2), "reload_done");
      applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 2), "reload_clear");
    end
    applyStimulus(cmd(0, 0, 0, 1, 0), runOut(0, 2), "reload_stop");
    applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 0), "reload_idle");
`else
    // Command table: limit=0, ignored commands, stop>start>pause, restart from PAUSED.
    vecs[0]  = '{cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{cmd(0, 0, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{cmd(1, 0, 0, 0, 0), outs(0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 0)};
    vecs[4]  = '{cmd(0, 0, 0, 0, 0), runOut(0, 0)};
    vecs[5]  = '{cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 1, 1, 0)};
    vecs[6]  = '{cmd(0, 1, 0, 0, 0), outs(0, 0, 0, 0, 1, 0, 0)};
    vecs[7]  = '{cmd(0, 0, 1, 0, 0), outs(0, 0, 0, 0, 1, 0, 0)};
    vecs[8]  = '{cmd(1, 0, 0, 0, 9), outs(0, 0, 0, 0, 1, 0, 0)};
    vecs[9]  = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 0)};
    vecs[10] = '{cmd(0, 0, 0, 0, 0), runOut(0, 9)};
    vecs[11] = '{cmd(0, 0, 0, 0, 0), runOut(1, 9)};
    vecs[12] = '{cmd(0, 0, 0, 0, 0), runOut(2, 9)};
    vecs[13] = '{cmd(0, 0, 0, 0, 0), runOut(3, 9)};
    vecs[14] = '{cmd(1, 1, 0, 1, 7), runOut(4, 9)};
    vecs[15] = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 1)};
    vecs[16] = '{cmd(0, 0, 1, 0, 0), outs(0, 0, 0, 0, 0, 0, 0)};
    vecs[17] = '{cmd(1, 1, 0, 0, 2), outs(0, 0, 0, 0, 0, 0, 0)};
    vecs[18] = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 0)};
    vecs[19] = '{cmd(0, 1, 0, 0, 0), runOut(0, 2)};
    vecs[20] = '{cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 1, 0, 0, 0)};
    vecs[21] = '{cmd(1, 0, 0, 0, 1), outs(0, 0, 0, 1, 0, 0, 0)};
    vecs[22] = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 0)};
    vecs[23] = '{cmd(0, 0, 0, 0, 0), runOut(0, 1)};
    vecs[24] = '{cmd(0, 0, 0, 0, 0), runOut(1, 1)};
    vecs[25] = '{cmd(0, 0, 0, 0, 0), runOut(2, 1)};
    vecs[26] = '{cmd(0, 0, 0, 0, 0), runOut(3, 1)};
    vecs[27] = '{cmd(0, 0, 0, 0, 0), runOut(4, 1)};
    vecs[28] = '{cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 1, 1, 1)};
    vecs[29] = '{cmd(0, 0, 0, 1, 0), outs(0, 0, 0, 0, 1, 0, 1)};
    vecs[30] = '{cmd(0, 0, 0, 0, 0), outs(0, 1, 0, 0, 0, 0, 1)};
    vecs[31] = '{cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 32; i++) applyStimulus(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    $display("[TB] limit=3 full run");
    startRun(3, outs(0, 0, 0, 0, 0, 0, 0), "l3_start");
    runSpan(0, 3 * PRESCALE, 3, "l3_run");
    expireSteps(3, 5, "l3_expired");

    $display("[TB] limit=5 with pause/resume");
    startRun(5, outs(0, 0, 0, 0, 1, 0, 3), "l5_start");
    runSpan(0, 8, 5, "l5_run");
    applyStimulus(cmd(0, 1, 0, 0, 0), runOut(9, 5), "l5_pause");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 1, 0, 0, 2), "l5_paused");
      checks++;
      if (dut.prescaler !== 3'd2) begin
        errors++;
        $display("[TB] FAIL l5_prescaler_frozen got=%0d required=2", dut.prescaler);
      end
    end
    applyStimulus(cmd(0, 0, 1, 0, 0), outs(0, 0, 0, 1, 0, 0, 2), "l5_resume");
    runSpan(10, 5 * PRESCALE, 5, "l5_run2");
    expireSteps(5, 2, "l5_expired");

    $display("[TB] asynchronous reset mid-run");
    startRun(2, outs(0, 0, 0, 0, 1, 0, 5), "rst_start");
    runSpan(0, 5, 2, "rst_run");
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(cmd(0, 0, 0, 0, 0), outs(0, 0, 0, 0, 0, 0, 1), "post_reset_idle");
    startRun(2, outs(0, 0, 0, 0, 0, 0, 1), "post_reset_start");
    runSpan(0, 2 * PRESCALE, 2, "post_reset_run");
    expireSteps(2, 2, "post_reset_expired");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
